// File: rtl/keypad_pkg.sv
// Shared keypad geometry and the (row, column) -> hex code map.
package keypad_pkg;

  localparam int unsigned COL_CNT = 4;
  localparam int unsigned ROW_CNT = 4;
  localparam int unsigned KEY_CNT = ROW_CNT * COL_CNT;

  typedef logic [1:0] col_idx_t;
  typedef logic [1:0] row_idx_t;

  localparam logic [3:0] KEY_MAP [ROW_CNT][COL_CNT] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'h0, 4'hF, 4'hE, 4'hD}
  };

  // Flat per-key index used for the debounce state arrays.
  function automatic logic [3:0] key_idx(input row_idx_t row, input col_idx_t col);
    return {row, col};
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Key-event queue: power-of-two depth, head visible combinationally,
// a push into a full queue succeeds only when a pop happens in the same cycle.
module key_fifo #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DATA_W     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign head_data = mem[rd_ptr];
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/keypad_scan_driver.sv
// 4x4 keypad scanner: column strobing, per-key debounce, event queue.
// Define KEYPAD_RELEASE_EVT_EN to also queue key-release events.
module keypad_scan_driver
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 100000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] col_n,
  input  logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_release,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       overflow
);

`ifdef KEYPAD_RELEASE_EVT_EN
  localparam int unsigned EVT_W = 5;
`else
  localparam int unsigned EVT_W = 4;
`endif
  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [ROW_CNT-1:0] row_meta;
  logic [ROW_CNT-1:0] row_sync;
  logic [DIV_W-1:0]   div_cnt;
  col_idx_t           col_idx;
  logic               sample_now;

  logic [KEY_CNT-1:0] key_state;
  logic [2:0]         deb_cnt [KEY_CNT];
  logic [ROW_CNT-1:0] row_was;
  logic [ROW_CNT-1:0] row_diff;
  logic [ROW_CNT-1:0] row_toggle;
  logic [ROW_CNT-1:0] emit_mask;

  logic [ROW_CNT-1:0] pend_mask;
  logic [ROW_CNT-1:0] cand_mask;
  logic [ROW_CNT-1:0] push_clr;
  col_idx_t           pend_col;
  col_idx_t           cand_col;
  row_idx_t           sel;
  logic               push;
  logic [EVT_W-1:0]   push_data;
  logic [EVT_W-1:0]   head_data;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;

  assign sample_now = (div_cnt == DIV_W'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_meta <= '1;
      row_sync <= '1;
      div_cnt  <= '0;
      col_idx  <= '0;
      col_n    <= 4'b1110;
    end else begin
      row_meta <= row_n;
      row_sync <= row_meta;
      if (sample_now) begin
        div_cnt <= '0;
        col_idx <= col_idx + 2'd1;
        col_n   <= ~(4'b0001 << (col_idx + 2'd1));
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    row_was    = '0;
    row_diff   = '0;
    row_toggle = '0;
    for (int unsigned r = 0; r < ROW_CNT; r++) begin
      row_was[r]    = key_state[key_idx(row_idx_t'(r), col_idx)];
      row_diff[r]   = (~row_sync[r]) ^ row_was[r];
      row_toggle[r] = sample_now && row_diff[r] &&
                      (deb_cnt[key_idx(row_idx_t'(r), col_idx)] == 3'(DEBOUNCE_SCANS - 1));
    end
  end

`ifdef KEYPAD_RELEASE_EVT_EN
  assign emit_mask = row_toggle;
`else
  assign emit_mask = row_toggle & ~row_was;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_state <= '0;
      for (int unsigned k = 0; k < KEY_CNT; k++) deb_cnt[k] <= '0;
    end else if (sample_now) begin
      for (int unsigned r = 0; r < ROW_CNT; r++) begin
        if (!row_diff[r]) begin
          deb_cnt[key_idx(row_idx_t'(r), col_idx)] <= '0;
        end else if (row_toggle[r]) begin
          key_state[key_idx(row_idx_t'(r), col_idx)] <= ~row_was[r];
          deb_cnt[key_idx(row_idx_t'(r), col_idx)]   <= '0;
        end else begin
          deb_cnt[key_idx(row_idx_t'(r), col_idx)] <=
            deb_cnt[key_idx(row_idx_t'(r), col_idx)] + 3'd1;
        end
      end
    end
  end

  // The first event of a sample is pushed in the sample cycle itself; the
  // rest drain one per cycle in row order, finishing before the next sample
  // as long as SCAN_DIV >= ROW_CNT.
  always_comb begin
    cand_mask = sample_now ? emit_mask : pend_mask;
    cand_col  = sample_now ? col_idx : pend_col;
    push      = 1'b0;
    sel       = '0;
    for (int unsigned r = 0; r < ROW_CNT; r++) begin
      if (cand_mask[r] && !push) begin
        push = 1'b1;
        sel  = row_idx_t'(r);
      end
    end
    push_clr = '0;
    if (push) push_clr[sel] = 1'b1;
  end

`ifdef KEYPAD_RELEASE_EVT_EN
  logic [ROW_CNT-1:0] pend_rel;
  logic [ROW_CNT-1:0] cand_rel;

  assign cand_rel  = sample_now ? row_was : pend_rel;
  assign push_data = {cand_rel[sel], KEY_MAP[sel][cand_col]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pend_rel <= '0;
    else      pend_rel <= cand_rel;
  end
`else
  assign push_data = KEY_MAP[sel][cand_col];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_mask <= '0;
      pend_col  <= '0;
      overflow  <= 1'b0;
    end else begin
      pend_mask <= cand_mask & ~push_clr;
      pend_col  <= cand_col;
      if (push && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  assign pop = key_valid && key_ready;

  key_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_W     (EVT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign key_valid = ~fifo_empty;
  assign key_code  = head_data[3:0];
`ifdef KEYPAD_RELEASE_EVT_EN
  assign key_release = head_data[4];
`else
  assign key_release = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scan_driver.sv
// Directed bench for keypad_scan_driver with a keypad model and an event scoreboard.
`timescale 1ns/1ps
module tb_keypad_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [3:0]  key_code;
  logic        key_release;
  logic        key_valid;
  logic        key_ready;
  logic        overflow;
  logic [15:0] keys;

  logic [4:0]  exp_q [$];
  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  // Pressed key at (r, c) pulls row r low while column c is strobed.
  always_comb begin
    row_n = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  keypad_scan_driver #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (2),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .col_n       (col_n),
    .row_n       (row_n),
    .key_code    (key_code),
    .key_release (key_release),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .overflow    (overflow)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_scans(input int n);
    repeat (16*n) @(negedge clk);
  endtask

  task automatic wait_col(input logic [3:0] target);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 64 && !hit; i++) begin
      @(negedge clk);
      if (col_n === target) hit = 1'b1;
    end
    check("wait_col", {7'b0, hit}, 8'd1);
  endtask

  task automatic align_scan();
    wait_col(4'b0111);
    wait_col(4'b1110);
  endtask

  task automatic expect_event();
    logic       hit;
    logic [4:0] expv;
    hit = 1'b0;
    for (int i = 0; i < 128 && !hit; i++) begin
      if (key_valid === 1'b1) hit = 1'b1;
      else @(negedge clk);
    end
    check("event_wait", {7'b0, hit}, 8'd1);
    expv = exp_q.pop_front();
    check("event", {3'b0, key_release, key_code}, {3'b0, expv});
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
  endtask

  task automatic drain_all();
    while (exp_q.size() > 0) expect_event();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] one_hot;
    rst       = 1'b0;
    keys      = '0;
    key_ready = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_col_n",   {4'b0, col_n}, 8'h0E);
    check("rst_valid",   {7'b0, key_valid}, 8'd0);
    check("rst_ovf",     {7'b0, overflow}, 8'd0);
    check("rst_code",    {4'b0, key_code}, 8'd0);
    check("rst_release", {7'b0, key_release}, 8'd0);

    rst = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      one_hot = 4'b0001 << (k / 4);
      check("col_seq", {4'b0, col_n}, {4'b0, ~one_hot});
    end

    // Key '5': one press event, holding it produces nothing more.
    keys[5] = 1'b1;
    wait_scans(4);
    exp_q.push_back({1'b0, 4'h5});
    check("k5_valid", {7'b0, key_valid}, 8'd1);
    repeat (5) @(negedge clk);
    check("k5_hold", {4'b0, key_code}, 8'h05);
    drain_all();
    wait_scans(4);
    check("k5_no_repeat", {7'b0, key_valid}, 8'd0);
    keys[5] = 1'b0;
    wait_scans(4);
`ifdef KEYPAD_RELEASE_EVT_EN
    exp_q.push_back({1'b1, 4'h5});
`endif
    drain_all();
    check("k5_done", {7'b0, key_valid}, 8'd0);

    // Key '9' seen on a single scan only.
    keys[10] = 1'b1;
    repeat (16) @(negedge clk);
    keys[10] = 1'b0;
    wait_scans(4);
    check("glitch_none", {7'b0, key_valid}, 8'd0);
    check("glitch_ovf",  {7'b0, overflow}, 8'd0);

    // Five keys with the consumer stalled: fifth event dropped.
    align_scan();
    keys = 16'h008F;
    wait_scans(3);
    exp_q.push_back({1'b0, 4'h1});
    exp_q.push_back({1'b0, 4'h2});
    exp_q.push_back({1'b0, 4'h3});
    exp_q.push_back({1'b0, 4'hA});
    check("ovf_set", {7'b0, overflow}, 8'd1);
    drain_all();
    check("ovf_sticky", {7'b0, overflow}, 8'd1);
    check("ovf_drained", {7'b0, key_valid}, 8'd0);
    align_scan();
    keys = '0;
    wait_scans(3);
`ifdef KEYPAD_RELEASE_EVT_EN
    exp_q.push_back({1'b1, 4'h1});
    exp_q.push_back({1'b1, 4'h2});
    exp_q.push_back({1'b1, 4'h3});
    exp_q.push_back({1'b1, 4'hA});
`endif
    drain_all();
    check("ovf_rel_done", {7'b0, key_valid}, 8'd0);

    // Key 'D' press then release.
    keys[15] = 1'b1;
    wait_scans(4);
    exp_q.push_back({1'b0, 4'hD});
    keys[15] = 1'b0;
    wait_scans(4);
`ifdef KEYPAD_RELEASE_EVT_EN
    exp_q.push_back({1'b1, 4'hD});
`endif
    drain_all();
    check("d_done", {7'b0, key_valid}, 8'd0);

    // Reset with two events queued.
    align_scan();
    keys[0] = 1'b1;
    keys[1] = 1'b1;
    wait_scans(3);
    check("pre_rst_valid", {7'b0, key_valid}, 8'd1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_valid", {7'b0, key_valid}, 8'd0);
    check("mid_rst_col",   {4'b0, col_n}, 8'h0E);
    check("mid_rst_ovf",   {7'b0, overflow}, 8'd0);
    check("mid_rst_code",  {4'b0, key_code}, 8'd0);
    keys = '0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    check("post_rst_col0", {4'b0, col_n}, 8'h0E);
    repeat (3) @(negedge clk);
    check("post_rst_col3", {4'b0, col_n}, 8'h0E);
    @(negedge clk);
    check("post_rst_col4", {4'b0, col_n}, 8'h0D);
    wait_scans(4);
    check("post_rst_empty", {7'b0, key_valid}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
